bus_dev_fifo: RTL and testbench
===============================

// Module: bus_dev_fifo
// PURPOSE
//  Per-device transmit FIFO that feeds the bus generator/arbiter; one instance per driver port.
//  Write side: the device agent loads packets. Read side: the arbiter sees pndng/D_pop and strobes pop when it grants the bus.
//  Packet format: [pckg_sz-1 -: 8] = destination ID (8'hFF = broadcast), remainder = payload.
//  The FIFO does not interpret the packet.
// PARAMETERS
//  pckg_sz   32    packet width in bits (>= 9)
//  depth     16    entries; power of two, >= 2; any other value -> $error at elaboration
//  af_lvl    14    almost_full asserts when count >= af_lvl (1..depth)
// PORTS
//  clk          in   1                    system clock, all logic on rising edge
//  reset        in   1                    asynchronous, active-high; clears all state
//  push         in   1                    write strobe from device agent
//  D_push       in   pckg_sz              packet written on push
//  pop          in   1                    read strobe from arbiter (consumes head)
//  D_pop        out  pckg_sz              head-of-queue packet (show-ahead)
//  pndng        out  1                    queue non-empty; D_pop valid
//  full         out  1                    count == depth
//  almost_full  out  1                    count >= af_lvl
//  count        out  $clog2(depth)+1      entries currently stored, 0..depth
//  overflow     out  1                    sticky: a push was dropped
//  underflow    out  1                    sticky: a pop arrived while empty
//  clr_flags    in   1                    synchronous clear of overflow/underflow
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - wr_ptr/rd_ptr/count = 0; pndng, full, almost_full, overflow, underflow = 0; D_pop = 0.
//   - Memory contents need not be cleared.
//   - Reset mid-traffic discards all queued packets.
//  Storage: depth x pckg_sz array. wr_ptr and rd_ptr are $clog2(depth) bits and wrap depth-1 -> 0 naturally.
//  All status outputs (pndng, full, almost_full, count) are registered and derived from next-state count.
//  Push latency:
//   - Push into an empty FIFO at edge N -> pndng=1 and D_pop=that packet after edge N.
//   - Both are visible in the cycle following N.
//  Read side is show-ahead. While pndng=1, D_pop = mem[rd_ptr]. While pndng=0, D_pop = 0 (masked).
//  Pop with pndng=1: rd_ptr++ and count-- at the edge; the next entry (or 0/pndng=0) is visible the following cycle.
//  The arbiter may pop on consecutive cycles: one packet per cycle sustained.
//  Accepted push: mem[wr_ptr] <= D_push; wr_ptr++; count++.
//  Simultaneous events per edge:
//   - push & pop, 0<count<depth: both performed, count unchanged.
//   - push & pop, full: both performed (pop frees the slot); count stays depth; overflow not set.
//   - push, no pop, full: packet dropped; pointers unchanged; overflow <= 1.
//   - pop, empty (incl. push & pop while empty): pop ignored; push accepted if present; underflow <= 1.
//  Sticky flags:
//   - Flags hold until clr_flags or reset.
//   - If clr_flags coincides with a new overflow/underflow event, the flag is set (set wins).
//  No combinational path from push/pop to any output.
// TESTING
//  1. Reset, push 32'hAA00_0001 once, no pop -> next cycle pndng=1, D_pop=32'hAA00_0001, count=1.
//     Then pop 1 cycle -> pndng=0, D_pop=0, count=0.
//  2. Push 16 pkts 0..15 (depth 16) -> full=1 after 16th; almost_full rose after 14th.
//     17th push -> dropped, overflow=1, count=16.
//     Pop 16 -> data 0..15 in order.
//  3. Fill to 16, then push+pop same cycle with pkt 16 -> count=16, overflow=0.
//     Drain yields 1..16; pointers wrap without corruption.
//  4. Empty FIFO, push 32'hFF00_1234 + pop same cycle -> underflow=1, count=1, D_pop=32'hFF00_1234 next cycle.
//     clr_flags -> underflow=0.
//  5. Queue 5 pkts, assert reset asynchronously mid-cycle -> all outputs 0 immediately (before next clk edge).
//     After release, push works from entry 0.
//  6. Random push/pop 10k cycles vs reference queue model -> order, count and flags match every cycle.

Source files
------------

// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: per-device transmit FIFO feeding the bus arbiter.
// The write side is driven by the device agent, and the read side is show-ahead.
// All status outputs and the head-of-queue data are registered and are computed
// from the next-state count and pointers. No input has a combinational path to any output.
module bus_dev_fifo #(
    parameter int pckg_sz = 32,
    parameter int depth   = 16,
    parameter int af_lvl  = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    input  logic                     pop,
    input  logic                     clr_flags,
    output logic [pckg_sz-1:0]       D_pop,
    output logic                     pndng,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(depth):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(af_lvl);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        $error("bus_dev_fifo: depth must be a power of two >= 2");
    end
    if (af_lvl < 1 || af_lvl > depth) begin : g_bad_af_lvl
        $error("bus_dev_fifo: af_lvl must lie in 1..depth");
    end
    if (pckg_sz < 9) begin : g_bad_pckg_sz
        $error("bus_dev_fifo: pckg_sz must be >= 9");
    end

    logic [pckg_sz-1:0] r_mem [depth];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [pckg_sz-1:0] r_d_pop;
    logic               r_pndng;
    logic               r_full;
    logic               r_almost_full;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_empty;
    logic               w_is_full;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_ovf_event;
    logic               w_unf_event;
    logic [CW-1:0]      w_next_count;
    logic [AW-1:0]      w_next_rd_ptr;
    logic [pckg_sz-1:0] w_next_head;

    assign w_empty   = (r_count == '0);
    assign w_is_full = (r_count == DEPTH_C);

    // A pop is honoured only when data is present. A push to a full queue
    // is honoured only if a pop frees the slot on the same edge.
    assign w_do_pop    = pop & ~w_empty;
    assign w_do_push   = push & (~w_is_full | w_do_pop);
    assign w_ovf_event = push & w_is_full & ~pop;
    assign w_unf_event = pop & w_empty;

    assign w_next_rd_ptr = w_do_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;

    // Next occupancy: a simultaneous accepted push and pop cancel each other out.
    // NOTE: every signal in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_next_count = r_count;
        if (w_do_push && !w_do_pop) begin
            w_next_count = r_count + ONE_C;
        end else if (w_do_pop && !w_do_push) begin
            w_next_count = r_count - ONE_C;
        end
    end

    // If the packet written on this edge will be the only entry, it is not yet in
    // r_mem, so it bypasses the array straight into the head register.
    assign w_next_head = (w_do_push && w_next_count == ONE_C) ? D_push : r_mem[w_next_rd_ptr];

    // Packet storage write port.
    // NOTE: the array has no reset. Stale contents are never visible because D_pop is masked by count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= D_push;
        end
    end

    // Pointers, occupancy, registered status/head outputs and sticky error flags.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_d_pop       <= '0;
            r_pndng       <= 1'b0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_rd_ptr      <= w_next_rd_ptr;
            r_count       <= w_next_count;
            r_pndng       <= (w_next_count != '0);
            r_full        <= (w_next_count == DEPTH_C);
            r_almost_full <= (w_next_count >= AF_C);
            r_d_pop       <= (w_next_count != '0) ? w_next_head : '0;
            // A new event on the same edge as clr_flags sets the flag.
            r_overflow    <= w_ovf_event | (r_overflow & ~clr_flags);
            r_underflow   <= w_unf_event | (r_underflow & ~clr_flags);
        end
    end

    assign D_pop       = r_d_pop;
    assign pndng       = r_pndng;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// tb_bus_dev_fifo: directed scenarios plus randomized traffic for bus_dev_fifo.
// A queue-based reference model is checked against every output on each falling edge.
module tb_bus_dev_fifo;

    localparam int PSZ   = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 14;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic            push      = 1'b0;
    logic            pop       = 1'b0;
    logic            clr_flags = 1'b0;
    logic [PSZ-1:0]  D_push    = '0;
    logic [PSZ-1:0]  D_pop;
    logic            pndng;
    logic            full;
    logic            almost_full;
    logic [4:0]      count;
    logic            overflow;
    logic            underflow;

    int  total  = 0;
    int  bad    = 0;
    bit  chk_en = 1'b0;

    // Reference model: the queue contents plus the two sticky flags.
    logic [PSZ-1:0] q[$];
    logic           m_ovf = 1'b0;
    logic           m_unf = 1'b0;

    always #5 clk = ~clk;

    bus_dev_fifo #(.pckg_sz(PSZ), .depth(DEPTH), .af_lvl(AF)) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .D_push     (D_push),
        .pop        (pop),
        .clr_flags  (clr_flags),
        .D_pop      (D_pop),
        .pndng      (pndng),
        .full       (full),
        .almost_full(almost_full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PSZ-1:0] model_head();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    // Reference model update, which applies the queue semantics to the inputs sampled at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
        end else begin
            m_ovf <= (push && !pop && q.size() == DEPTH) || (m_ovf && !clr_flags);
            m_unf <= (pop && q.size() == 0) || (m_unf && !clr_flags);
            if (pop && q.size() != 0) begin
                void'(q.pop_front());
                if (push) q.push_back(D_push);
            end else if (push && q.size() < DEPTH) begin
                q.push_back(D_push);
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_pndng",  pndng,       q.size() != 0);
            check("cyc_d_pop",  D_pop,       model_head());
            check("cyc_count",  count,       64'(q.size()));
            check("cyc_full",   full,        q.size() == DEPTH);
            check("cyc_afull",  almost_full, q.size() >= AF);
            check("cyc_ovf",    overflow,    m_ovf);
            check("cyc_unf",    underflow,   m_unf);
        end
    end

    // Apply one cycle of inputs. They are driven on the falling edge and sampled on the next rising edge.
    task automatic step(input logic p, input logic [PSZ-1:0] d, input logic o, input logic c);
        @(negedge clk);
        push      = p;
        D_push    = d;
        pop       = o;
        clr_flags = c;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int pp;
        int op;
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_pndng", pndng, 1'b0);
        check("rst_count", count, 5'd0);
        check("rst_d_pop", D_pop, 32'h0);
        check("rst_flags", {full, almost_full, overflow, underflow}, 4'b0000);
        reset  = 1'b0;
        chk_en = 1'b1;

        // 1: a single push, then a single pop.
        step(1'b1, 32'hAA00_0001, 1'b0, 1'b0);
        idle();
        check("t1_pndng", pndng, 1'b1);
        check("t1_d_pop", D_pop, 32'hAA00_0001);
        check("t1_count", count, 5'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        check("t1_pop_pndng", pndng, 1'b0);
        check("t1_pop_d_pop", D_pop, 32'h0);
        check("t1_pop_count", count, 5'd0);

        // 2: fill the queue, push once more to overflow, then drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 14) check("t2_afull_at14", almost_full, 1'b1);
            if (i == 13) check("t2_afull_at13", almost_full, 1'b0);
        end
        step(1'b1, 32'd16, 1'b0, 1'b0);
        check("t2_full", full, 1'b1);
        idle();
        check("t2_overflow", overflow, 1'b1);
        check("t2_count", count, 5'd16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("t2_order", D_pop, 32'(i));
        end
        step(1'b0, '0, 1'b0, 1'b1);
        idle();
        check("t2_clr", overflow, 1'b0);

        // 3: at full, a push and a pop on the same cycle, then a drain of 1..16.
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'd16, 1'b1, 1'b0);
        idle();
        check("t3_count", count, 5'd16);
        check("t3_ovf", overflow, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("t3_order", D_pop, 32'(i));
        end
        idle();

        // 4: a push and a pop on the same cycle while the queue is empty.
        step(1'b1, 32'hFF00_1234, 1'b1, 1'b0);
        idle();
        check("t4_unf", underflow, 1'b1);
        check("t4_count", count, 5'd1);
        check("t4_d_pop", D_pop, 32'hFF00_1234);
        step(1'b0, '0, 1'b0, 1'b1);
        idle();
        check("t4_clr", underflow, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();

        // 5: an asynchronous reset asserted in the middle of a cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h5A00_0000 + 32'(i), 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_async_count", count, 5'd0);
        check("t5_async_pndng", pndng, 1'b0);
        check("t5_async_d_pop", D_pop, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h0055_0055, 1'b0, 1'b0);
        idle();
        check("t5_after_d_pop", D_pop, 32'h0055_0055);
        check("t5_after_count", count, 5'd1);

        // 6: randomized traffic in phases that bias the queue toward full, empty and mixed occupancy.
        for (int ph = 0; ph < 10; ph++) begin
            case (ph % 5)
                0: begin pp = 90; op = 20; end
                1: begin pp = 20; op = 90; end
                2: begin pp = 50; op = 50; end
                3: begin pp = 85; op = 80; end
                default: begin pp = 100; op = 5; end
            endcase
            for (int c = 0; c < 1000; c++) begin
                step($urandom_range(99) < pp, $urandom, $urandom_range(99) < op,
                     $urandom_range(15) == 0);
            end
        end
        idle();
        idle();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
